// File: rtl/uop_dispatch_queue.sv
// In-order micro-op queue between decode and the ALU/FPU/LSU reservation stations.
// The oldest entry issues to exactly one port. A younger entry never overtakes a stalled head.
module uop_dispatch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PAY_W = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_op,
    input  logic                     in_is_fpu,
    input  logic                     in_mem_rd,
    input  logic                     in_mem_wr,
    input  logic [PAY_W-1:0]         in_payload,
    output logic                     alu_valid,
    output logic                     fpu_valid,
    output logic                     lsu_valid,
    input  logic                     alu_ready,
    input  logic                     fpu_ready,
    input  logic                     lsu_ready,
    output logic [4:0]               out_op,
    output logic                     out_is_store,
    output logic                     out_is_fpu,
    output logic [PAY_W-1:0]         out_payload,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              stall_cycles
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    typedef enum logic [1:0] {
        ClsAlu = 2'd0,
        ClsFpu = 2'd1,
        ClsLsu = 2'd2
    } cls_e;

    logic [4:0]       op_mem    [DEPTH];
    cls_e             cls_mem   [DEPTH];
    logic             store_mem [DEPTH];
    logic             fpu_mem   [DEPTH];
    logic [PAY_W-1:0] pay_mem   [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   stall_q, stall_d;

    cls_e in_cls;
    cls_e head_cls;
    logic head_valid;
    logic sel_ready;
    logic push;
    logic pop;

    // Memory ops win over the F flag so float loads/stores land on the LSU.
    always_comb begin
        in_cls = ClsAlu;
        if (in_mem_rd || in_mem_wr) begin
            in_cls = ClsLsu;
        end else if (in_is_fpu) begin
            in_cls = ClsFpu;
        end
    end

    assign in_ready   = (count_q != DepthC);
    assign head_valid = (count_q != '0);
    assign head_cls   = cls_mem[rd_ptr_q];
    assign push       = in_valid && in_ready && !flush;
    assign pop        = head_valid && sel_ready && !flush;

    always_comb begin
        alu_valid = 1'b0;
        fpu_valid = 1'b0;
        lsu_valid = 1'b0;
        sel_ready = 1'b0;
        case (head_cls)
            ClsFpu: begin
                fpu_valid = head_valid;
                sel_ready = fpu_ready;
            end
            ClsLsu: begin
                lsu_valid = head_valid;
                sel_ready = lsu_ready;
            end
            default: begin
                alu_valid = head_valid;
                sel_ready = alu_ready;
            end
        endcase
    end

    assign out_op       = op_mem[rd_ptr_q];
    assign out_is_store = store_mem[rd_ptr_q];
    assign out_is_fpu   = fpu_mem[rd_ptr_q];
    assign out_payload  = pay_mem[rd_ptr_q];
    assign count        = count_q;
    assign stall_cycles = stall_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        stall_d  = stall_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (head_valid && !sel_ready && (stall_q != 16'hFFFF)) begin
                stall_d = stall_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    // Storage is not reset; head outputs are only meaningful while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q]    <= in_op;
            cls_mem[wr_ptr_q]   <= in_cls;
            store_mem[wr_ptr_q] <= in_mem_wr;
            fpu_mem[wr_ptr_q]   <= in_is_fpu;
            pay_mem[wr_ptr_q]   <= in_payload;
        end
    end

endmodule

// File: doc/uop_dispatch_queue.md
Name: uop_dispatch_queue

Overview:
- In-order buffer between instruction decode and the execution-side reservation stations.
- Accepts one decoded micro-op per cycle from decode: the 5-bit unified opcode plus class flags and an opaque payload.
- Holds up to DEPTH entries and issues the oldest entry to exactly one of three ports: integer ALU, FPU, or load/store.
- Provides back-pressure to decode and supports a single-cycle pipeline flush.

Parameters:
DEPTH, 4, queue entries; power of two, ≥2.
PAY_W, 64, width of the opaque payload (pc, rd, rs indices, imm select, write-enables), passed through unmodified.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  discard all entries and any same-cycle input.
in_valid  in  1  decode has a micro-op.
in_ready  out  1  queue can accept this cycle.
in_op  in  5  unified opcode (ALU or FPU encoding, 0..31).
in_is_fpu  in  1  instruction belongs to the F extension.
in_mem_rd  in  1  load (integer or float).
in_mem_wr  in  1  store (integer or float).
in_payload  in  PAY_W  opaque bundle.
alu_valid / fpu_valid / lsu_valid  out  1 each  head is issued to that port.
alu_ready / fpu_ready / lsu_ready  in  1 each  port accepts.
out_op  out  5  head opcode, shared by all ports.
out_is_store  out  1  head in_mem_wr.
out_is_fpu  out  1  head in_is_fpu.
out_payload  out  PAY_W  head payload, shared.
count  out  clog2(DEPTH)+1  current occupancy.
stall_cycles  out  16  saturating count of cycles with head valid and target port not ready.

Behaviour:
- Reset (async, rst_n=0):
  - Read/write pointers = 0, count = 0, stall_cycles = 0.
  - All *_valid = 0, in_ready = 1.
  - Storage contents need not reset.
- Class computed at enqueue, stored as a 2-bit tag:
  - LSU if in_mem_rd|in_mem_wr. This takes priority over in_is_fpu, so float load/store go to LSU.
  - Else FPU if in_is_fpu.
  - Else ALU. This includes branch, jump, LUI, AUIPC, M-extension.
- in_ready = (count < DEPTH). It is a function of registered state only; it has no combinational path from any port ready.
- Push = in_valid & in_ready & ~flush. The entry is written at the clock edge.
- Head visibility:
  - A pushed entry is visible at the head no earlier than the next cycle; there is no bypass.
  - Enqueue-to-issue latency is 1 cycle minimum.
- Head valid = count != 0.
  - Exactly one of alu_valid/fpu_valid/lsu_valid equals head valid, selected by the head class tag; the other two are 0.
  - out_op, out_is_store, out_is_fpu and out_payload reflect the head entry. Their values when count=0 are don't-care.
- Pop = head valid & ready of the selected port. The read pointer advances at the edge.
- Only the head may issue. A younger entry never bypasses a stalled head, even if its port is ready.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - When full, push is refused (in_ready=0) even if a pop occurs the same cycle.
- Pointers wrap modulo DEPTH.
- Once *_valid is asserted it must remain asserted with stable out_* until the pop or a flush (valid/ready hold rule).
- Flush:
  - At the next edge, pointers = 0 and count = 0.
  - The same-cycle push and pop are both suppressed. Ports may observe ready&valid during the flush cycle but must treat the flush as overriding.
  - stall_cycles is not cleared by flush.
- stall_cycles increments when head valid & ~selected_ready & ~flush, and saturates at 16'hFFFF.
- Ready inputs on non-selected ports are ignored.
- Reset asserted mid-operation discards all entries immediately (asynchronously); behaviour after release equals post-reset.

Test Plan:
- Reset then push ADD (op 0, no flags) with alu_ready=1:
  - alu_valid=1 exactly one cycle after the push, out_op=0.
  - fpu_valid=lsu_valid=0; count returns to 0.
- Push FLW (in_is_fpu=1, in_mem_rd=1), then FADD (in_is_fpu=1, op 0), with all readies high:
  - First issue on lsu_valid with out_is_fpu=1; next cycle fpu_valid with out_op=0.
  - Order is preserved.
- Hold lsu_ready=0 with an SW at the head and an ALU op behind it:
  - alu_valid stays 0 and lsu_valid stays 1 with stable payload.
  - stall_cycles increments each cycle.
  - After lsu_ready=1: SW issues, then the ALU op issues.
- All readies low, push 4 entries:
  - count=4, in_ready=0; a fifth in_valid is not accepted.
  - Raise alu_ready for one cycle with push attempted: count=3 and no write occurs.
  - Next cycle in_ready=1.
- Push/pop every cycle for 10 ops with DEPTH=4:
  - Pointers wrap, all 10 payloads emerge in order.
  - count stays 1 in steady state.
- Queue holding 3 entries, assert flush with in_valid=1 and the head port ready:
  - Next cycle count=0, all *_valid=0, and neither the input nor the head is consumed.
  - Asserting rst_n=0 mid-stream gives count=0 without a clock edge.
